// File: rtl/coord_to_complex.sv
// Maps integer pixel coordinates to fixed-point complex points (cx + x*step, cy + y*step).
// Two-stage pipeline (multiply, add+saturate) with ready/valid stall and frame-latched config.
module coord_to_complex #(
    parameter int FRAC_BITS = 24,
    parameter int OUT_W     = 32,
    parameter int STEP_W    = 24
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic signed [15:0]      in_x,
    input  logic signed [15:0]      in_y,
    input  logic                    in_first,
    input  logic                    in_lastx,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [OUT_W-1:0] cfg_cx,
    input  logic signed [OUT_W-1:0] cfg_cy,
    input  logic [STEP_W-1:0]       cfg_step,
    output logic signed [OUT_W-1:0] out_re,
    output logic signed [OUT_W-1:0] out_im,
    output logic                    out_first,
    output logic                    out_lastx,
    output logic                    out_valid,
    input  logic                    out_ready
);
    localparam int PW = 16 + STEP_W + 1;
    localparam int SW = ((OUT_W > PW) ? OUT_W : PW) + 1;

    localparam logic signed [SW-1:0]    SUM_MAX = SW'({1'b0, {(OUT_W-1){1'b1}}});
    localparam logic signed [SW-1:0]    SUM_MIN = ~SUM_MAX;
    localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] OUT_MIN = ~OUT_MAX;

    // Step is 0.FRAC_BITS and the centres need at least a sign bit above the fraction.
    if (STEP_W > FRAC_BITS || FRAC_BITS >= OUT_W) begin : g_bad_frac
        $error("coord_to_complex: inconsistent FRAC_BITS/STEP_W/OUT_W");
    end

    function automatic logic signed [OUT_W-1:0] sat(input logic signed [SW-1:0] v);
        if (v > SUM_MAX)
            sat = OUT_MAX;
        else if (v < SUM_MIN)
            sat = OUT_MIN;
        else
            sat = v[OUT_W-1:0];
    endfunction

    logic en;
    logic load_cfg;

    logic signed [OUT_W-1:0] cx_sh_q, cy_sh_q;
    logic [STEP_W-1:0]       step_sh_q;

    logic signed [OUT_W-1:0] cx_d, cy_d;
    logic [STEP_W-1:0]       step_d;
    logic signed [PW-1:0]    x_w, y_w, step_w, px_d, py_d;

    logic                    vld_p1_q;
    logic signed [PW-1:0]    px_p1_q, py_p1_q;
    logic signed [OUT_W-1:0] cx_p1_q, cy_p1_q;
    logic                    first_p1_q, lastx_p1_q;

    logic signed [SW-1:0]    re_sum_d, im_sum_d;

    logic                    vld_p2_q;
    logic signed [OUT_W-1:0] re_p2_q, im_p2_q;
    logic                    first_p2_q, lastx_p2_q;

    assign en       = !vld_p2_q || out_ready;
    assign in_ready = en;
    assign load_cfg = in_valid && en && in_first;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cx_sh_q   <= '0;
            cy_sh_q   <= '0;
            step_sh_q <= '0;
        end else if (load_cfg) begin
            cx_sh_q   <= cfg_cx;
            cy_sh_q   <= cfg_cy;
            step_sh_q <= cfg_step;
        end
    end

    // The frame's first beat sees the fresh config before the shadows update.
    always_comb begin
        cx_d   = load_cfg ? cfg_cx   : cx_sh_q;
        cy_d   = load_cfg ? cfg_cy   : cy_sh_q;
        step_d = load_cfg ? cfg_step : step_sh_q;
        x_w    = PW'(in_x);
        y_w    = PW'(in_y);
        step_w = PW'($signed({1'b0, step_d}));
        px_d   = x_w * step_w;
        py_d   = y_w * step_w;
    end

    // Stage 1: products and the centre chosen for this beat
    always_ff @(posedge clk) begin
        if (!resetn)
            vld_p1_q <= 1'b0;
        else if (en)
            vld_p1_q <= in_valid;
    end

    always_ff @(posedge clk) begin
        if (en) begin
            px_p1_q    <= px_d;
            py_p1_q    <= py_d;
            cx_p1_q    <= cx_d;
            cy_p1_q    <= cy_d;
            first_p1_q <= in_first;
            lastx_p1_q <= in_lastx;
        end
    end

    always_comb begin
        re_sum_d = SW'(cx_p1_q) + SW'(px_p1_q);
        im_sum_d = SW'(cy_p1_q) + SW'(py_p1_q);
    end

    // Stage 2: add and saturate; these registers drive the outputs
    always_ff @(posedge clk) begin
        if (!resetn) begin
            vld_p2_q   <= 1'b0;
            re_p2_q    <= '0;
            im_p2_q    <= '0;
            first_p2_q <= 1'b0;
            lastx_p2_q <= 1'b0;
        end else if (en) begin
            vld_p2_q   <= vld_p1_q;
            re_p2_q    <= sat(re_sum_d);
            im_p2_q    <= sat(im_sum_d);
            first_p2_q <= first_p1_q;
            lastx_p2_q <= lastx_p1_q;
        end
    end

    assign out_re    = re_p2_q;
    assign out_im    = im_p2_q;
    assign out_first = first_p2_q;
    assign out_lastx = lastx_p2_q;
    assign out_valid = vld_p2_q;
endmodule

// File: tb/tb_coord_to_complex.sv
// Randomized and directed bench for coord_to_complex against a queue-based reference model.
module tb_coord_to_complex;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               resetn;
    logic signed [15:0] in_x, in_y;
    logic               in_first, in_lastx, in_valid, in_ready;
    logic signed [31:0] cfg_cx, cfg_cy;
    logic [23:0]        cfg_step;
    logic [31:0]        out_re, out_im;
    logic               out_first, out_lastx, out_valid, out_ready;

    coord_to_complex dut (
        .clk(clk), .resetn(resetn),
        .in_x(in_x), .in_y(in_y), .in_first(in_first), .in_lastx(in_lastx),
        .in_valid(in_valid), .in_ready(in_ready),
        .cfg_cx(cfg_cx), .cfg_cy(cfg_cy), .cfg_step(cfg_step),
        .out_re(out_re), .out_im(out_im), .out_first(out_first), .out_lastx(out_lastx),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    typedef struct {
        logic [31:0] re;
        logic [31:0] im;
        logic        first;
        logic        lastx;
    } beat_t;

    beat_t       exp_q[$];
    logic [31:0] sh_cx, sh_cy;
    logic [23:0] sh_step;
    logic [31:0] last_re, last_im;
    logic        acc;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          popped  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] sat32(input longint v);
        if (v > 64'sd2147483647)
            return 32'h7FFFFFFF;
        else if (v < -64'sd2147483648)
            return 32'h80000000;
        else
            return v[31:0];
    endfunction

    task automatic push_model();
        beat_t b;
        if (in_first) begin
            sh_cx   = cfg_cx;
            sh_cy   = cfg_cy;
            sh_step = cfg_step;
        end
        b.re    = sat32(longint'($signed(sh_cx)) + longint'(in_x) * longint'(sh_step));
        b.im    = sat32(longint'($signed(sh_cy)) + longint'(in_y) * longint'(sh_step));
        b.first = in_first;
        b.lastx = in_lastx;
        exp_q.push_back(b);
    endtask

    // One clock: observe mid-cycle, update the model, then return just after the edge.
    task automatic cycle();
        @(negedge clk);
        check("in_ready", {31'b0, in_ready}, {31'b0, (!out_valid) || out_ready});
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", 32'd1, 32'd0);
            end else begin
                check("re", out_re, exp_q[0].re);
                check("im", out_im, exp_q[0].im);
                check("first", {31'b0, out_first}, {31'b0, exp_q[0].first});
                check("lastx", {31'b0, out_lastx}, {31'b0, exp_q[0].lastx});
                if (out_ready && resetn) begin
                    last_re = out_re;
                    last_im = out_im;
                    void'(exp_q.pop_front());
                    popped++;
                end
            end
        end
        acc = resetn && in_valid && in_ready;
        if (acc) push_model();
        @(posedge clk);
        #1;
        if (!resetn) begin
            exp_q.delete();
            sh_cx   = '0;
            sh_cy   = '0;
            sh_step = '0;
        end
    endtask

    task automatic send(input int x, input int y, input logic first, input logic lastx);
        int guard;
        in_x = 16'(x); in_y = 16'(y); in_first = first; in_lastx = lastx; in_valid = 1'b1;
        guard = 0;
        acc = 1'b0;
        while (!acc && guard < 50) begin
            cycle();
            guard++;
        end
        check("send_accepted", {31'b0, acc}, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        guard = 0;
        while (exp_q.size() > 0 && guard < 50) begin
            cycle();
            guard++;
        end
        check("drain_empty", exp_q.size(), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx, guard, pop0;
        sh_cx = '0; sh_cy = '0; sh_step = '0;
        resetn = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        in_x = 16'sd3; in_y = 16'sd4; in_first = 1'b1; in_lastx = 1'b1;
        cfg_cx = 32'h01234567; cfg_cy = 32'h01234567; cfg_step = 24'h123456;

        // Reset with valid input
        repeat (3) cycle();
        check("rst_valid", {31'b0, out_valid}, 32'd0);
        check("rst_re", out_re, 32'd0);
        check("rst_im", out_im, 32'd0);
        check("rst_first", {31'b0, out_first}, 32'd0);
        check("rst_lastx", {31'b0, out_lastx}, 32'd0);
        resetn = 1'b1; in_valid = 1'b0;
        #1;
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);

        // Basic mapping and 2-cycle latency
        cfg_cx = 32'hFF800000; cfg_cy = 32'h0; cfg_step = 24'h000400;
        in_x = -16'sd512; in_y = 16'sd512; in_first = 1'b1; in_lastx = 1'b0; in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        cycle();
        check("lat_valid", {31'b0, out_valid}, 32'd1);
        check("lat_re", out_re, 32'hFF780000);
        check("lat_im", out_im, 32'h00080000);
        check("lat_first", {31'b0, out_first}, 32'd1);
        drain();

        // Mid-frame cfg change ignored until next first beat
        cfg_cx = 32'h01000000; cfg_cy = 32'h02000000; cfg_step = 24'h000ABC;
        send(0, 0, 1'b1, 1'b0); drain();
        check("cfg_first_re", last_re, 32'h01000000);
        cfg_cx = 32'h05000000; cfg_cy = 32'h06000000;
        send(0, 0, 1'b0, 1'b0); drain();
        check("cfg_mid_re", last_re, 32'h01000000);
        check("cfg_mid_im", last_im, 32'h02000000);
        send(0, 0, 1'b1, 1'b0); drain();
        check("cfg_new_re", last_re, 32'h05000000);
        check("cfg_new_im", last_im, 32'h06000000);

        // Saturation at both ends
        cfg_cx = 32'h7FFFFFFF; cfg_cy = 32'h0; cfg_step = 24'hFFFFFF;
        send(511, 0, 1'b1, 1'b0); drain();
        check("sat_hi", last_re, 32'h7FFFFFFF);
        cfg_cx = 32'h80000000;
        send(-512, 0, 1'b1, 1'b0); drain();
        check("sat_lo", last_re, 32'h80000000);

        // Random stream with backpressure and config noise
        idx = 0; guard = 0; pop0 = popped;
        while (idx < 1024 && guard < 20000) begin
            in_valid  = ($urandom % 4) != 0;
            in_x      = 16'(idx - 512);
            in_y      = 16'(idx / 8 - 64);
            in_first  = (idx % 256) == 0;
            in_lastx  = (idx % 1024) == 1023;
            out_ready = ($urandom % 3) != 0;
            cfg_cx    = ($urandom % 2) ? $urandom : 32'($signed($urandom_range(0, 32'h00FFFFFF)) - 32'sh00800000);
            cfg_cy    = $urandom;
            cfg_step  = ($urandom % 2) ? 24'($urandom) : 24'($urandom % 4096);
            cycle();
            if (acc) idx++;
            guard++;
        end
        check("stream_sent", idx, 32'd1024);
        drain();
        check("stream_count", popped - pop0, 32'd1024);

        // Reset with both stages full and stalled
        out_ready = 1'b0;
        cfg_cx = 32'h00400000; cfg_cy = 32'h00300000; cfg_step = 24'h001000;
        send(1, 2, 1'b1, 1'b0);
        send(3, 4, 1'b0, 1'b1);
        check("full_valid", {31'b0, out_valid}, 32'd1);
        check("full_stall", {31'b0, in_ready}, 32'd0);
        resetn = 1'b0;
        cycle();
        check("midrst_valid", {31'b0, out_valid}, 32'd0);
        check("midrst_re", out_re, 32'd0);
        resetn = 1'b1;
        out_ready = 1'b1;
        cfg_cx = 32'h11111111; cfg_cy = 32'h22222222; cfg_step = 24'h333333;
        send(100, -7, 1'b0, 1'b0); drain();
        check("shadow_zero_re", last_re, 32'd0);
        check("shadow_zero_im", last_im, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
